guess_check_seq: RTL and testbench

Multi-cycle guess checker that the game controller sequences with a start pulse. On a start pulse it captures the player's BCD guess and the secret number. It then walks every guess-digit/secret-digit pair with a nested counter and produces a packed exact-match/partial-match result, a done pulse and a win flag. It sits between the game controller (check_start in, check_result back) and the switch input and random-number generator.

---
 rtl/guess_check_seq_if.sv | 23 ++
 rtl/guess_check_seq.sv | 159 +++++++++++++++
 tb/tb_guess_check_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/guess_check_seq_if.sv
// Handshake and data bundle between the game controller and guess_check_seq.
// The controller drives the master side; the checker takes the slave side.
interface guess_check_seq_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  check_start;
  logic [4*DIGITS-1:0]   guess;
  logic [4*DIGITS-1:0]   secret;
  logic                  busy;
  logic                  done;
  logic [7:0]            check_result;
  logic                  win;

  modport master (
    output check_start, guess, secret,
    input  busy, done, check_result, win
  );

  modport slave (
    input  check_start, guess, secret,
    output busy, done, check_result, win
  );
endinterface

// File: rtl/guess_check_seq.sv
// Multi-cycle BCD guess checker: nested (i,j) scan producing {exact,partial} counts.
// Define GUESS_VALIDATE_EN to add a guess-validation pass (nibble range and duplicates).
module guess_check_seq #(
  parameter int unsigned DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  guess_check_seq_if.slave bus
);
  localparam logic [3:0] LAST = 4'(DIGITS - 1);
  localparam logic [3:0] FULL = 4'(DIGITS);

`ifdef GUESS_VALIDATE_EN
  typedef enum logic [1:0] {IDLE, VALIDATE, SCAN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

  state_t              state_q;
  logic [4*DIGITS-1:0] guess_q;
  logic [4*DIGITS-1:0] secret_q;
  logic [3:0]          i_q;
  logic [3:0]          j_q;
  logic [3:0]          a_q;
  logic [3:0]          b_q;
  logic                exact_q;
  logic                partial_q;
  logic                busy_q;
  logic                done_q;
  logic [7:0]          result_q;
  logic                win_q;

  logic [3:0] gi;
  logic [3:0] sj;
  logic       same_idx;
  logic       exact_d;
  logic       partial_d;

`ifdef GUESS_VALIDATE_EN
  logic       invalid_q;
  logic       invalid_d;
  logic [3:0] gj;
`endif

  always_comb begin
    gi        = guess_q[4*i_q +: 4];
    sj        = secret_q[4*j_q +: 4];
    same_idx  = (i_q == j_q);
    exact_d   = exact_q   | (same_idx  & (gi == sj));
    partial_d = partial_q | (!same_idx & (gi == sj));
`ifdef GUESS_VALIDATE_EN
    gj        = guess_q[4*j_q +: 4];
    invalid_d = invalid_q | (gi > 4'd9) | (!same_idx & (gi == gj));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      guess_q   <= '0;
      secret_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      exact_q   <= 1'b0;
      partial_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      win_q     <= 1'b0;
`ifdef GUESS_VALIDATE_EN
      invalid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.check_start) begin
            guess_q   <= bus.guess;
            secret_q  <= bus.secret;
            i_q       <= '0;
            j_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            exact_q   <= 1'b0;
            partial_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef GUESS_VALIDATE_EN
            invalid_q <= 1'b0;
            state_q   <= VALIDATE;
`else
            state_q   <= SCAN;
`endif
          end
        end
`ifdef GUESS_VALIDATE_EN
        VALIDATE: begin
          invalid_q <= invalid_d;
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              i_q     <= '0;
              state_q <= invalid_d ? DONE : SCAN;
            end else begin
              i_q <= i_q + 4'd1;
            end
          end else begin
            j_q <= j_q + 4'd1;
          end
        end
`endif
        SCAN: begin
          // The final pair of each row folds into the counts via the _d flags directly.
          if (j_q == LAST) begin
            j_q       <= '0;
            exact_q   <= 1'b0;
            partial_q <= 1'b0;
            if (exact_d)        a_q <= a_q + 4'd1;
            else if (partial_d) b_q <= b_q + 4'd1;
            if (i_q == LAST) begin
              i_q     <= '0;
              state_q <= DONE;
            end else begin
              i_q <= i_q + 4'd1;
            end
          end else begin
            j_q       <= j_q + 4'd1;
            exact_q   <= exact_d;
            partial_q <= partial_d;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef GUESS_VALIDATE_EN
          if (invalid_q) begin
            result_q <= '1;
            win_q    <= 1'b0;
          end else begin
            result_q <= {a_q, b_q};
            win_q    <= (a_q == FULL);
          end
`else
          result_q <= {a_q, b_q};
          win_q    <= (a_q == FULL);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.check_result = result_q;
  assign bus.win          = win_q;
endmodule

// File: tb/tb_guess_check_seq.sv
// Directed self-checking bench for guess_check_seq with DIGITS=3.
module tb_guess_check_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp  = 0;
  int n_fail = 0;

`ifdef GUESS_VALIDATE_EN
  localparam int LAT_OK = 19;
`else
  localparam int LAT_OK = 10;
`endif

  guess_check_seq_if #(.DIGITS(3)) bus ();
  guess_check_seq #(.DIGITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns #1 after the accepting edge.
  task automatic start(input logic [11:0] g, input logic [11:0] s);
    @(negedge clk);
    bus.guess = g; bus.secret = s; bus.check_start = 1'b1;
    @(posedge clk); #1;
    bus.check_start = 1'b0;
  endtask

  // Counts edges after acceptance until done, tracking busy on the way.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic [11:0] g, input logic [11:0] s,
                     input logic [7:0] exp_res, input logic exp_win, input int exp_lat);
    int lat; bit bok;
    start(g, s);
    chk({tag, "_busy0"}, bus.busy, 1'b1);
    wait_done(lat, bok);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bok, 1'b1);
    chk({tag, "_res"}, bus.check_result, exp_res);
    chk({tag, "_win"}, bus.win, exp_win);
    chk({tag, "_busyoff"}, bus.busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_donepulse"}, bus.done, 1'b0);
    chk({tag, "_hold"}, bus.check_result, exp_res);
  endtask

  initial begin
    int lat; int ndone; bit bok;
    bus.check_start = 1'b0; bus.guess = '0; bus.secret = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_res", bus.check_result, 8'h00);
    chk("rst_win", bus.win, 1'b0);
    @(negedge clk); rst = 1'b1;

    run("t1_exact", 12'h123, 12'h123, 8'h30, 1'b1, LAT_OK);
    run("t2_mix", 12'h321, 12'h123, 8'h12, 1'b0, LAT_OK);
    run("t2_none", 12'h456, 12'h123, 8'h00, 1'b0, LAT_OK);

    // Second start three cycles into a check must be dropped.
    start(12'h321, 12'h123);
    ndone = 0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 4) begin bus.guess = 12'h123; bus.check_start = 1'b1; end
      if (k == 5) bus.check_start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin ndone++; if (lat == 0) lat = k; end
    end
    chk("t3_ndone", ndone, 1);
    chk("t3_lat", lat, LAT_OK);
    chk("t3_res", bus.check_result, 8'h12);

    // start held high through DONE is accepted on the following IDLE cycle.
    @(negedge clk);
    bus.guess = 12'h123; bus.secret = 12'h123; bus.check_start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat, bok);
    chk("t3b_lat", lat, LAT_OK);
    @(posedge clk); #1;
    chk("t3b_reaccept", bus.busy, 1'b1);
    bus.check_start = 1'b0;
    wait_done(lat, bok);
    chk("t3b_lat2", lat, LAT_OK);
    chk("t3b_res", bus.check_result, 8'h30);
    chk("t3b_win", bus.win, 1'b1);

    // Asynchronous reset mid-scan clears published result at once.
    start(12'h456, 12'h123);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t4_busy", bus.busy, 1'b0);
    chk("t4_done", bus.done, 1'b0);
    chk("t4_res", bus.check_result, 8'h00);
    chk("t4_win", bus.win, 1'b0);
    @(negedge clk); rst = 1'b1;
    run("t4_after", 12'h321, 12'h123, 8'h12, 1'b0, LAT_OK);

`ifdef GUESS_VALIDATE_EN
    run("t5_dup", 12'h112, 12'h123, 8'hFF, 1'b0, 10);
    run("t6_range", 12'h1A3, 12'h123, 8'hFF, 1'b0, 10);
    run("t6_ok", 12'h123, 12'h123, 8'h30, 1'b1, 19);
`else
    run("t5_dup", 12'h112, 12'h123, 8'h12, 1'b0, 10);
    run("t6_raw", 12'h1A3, 12'h1A3, 8'h30, 1'b1, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
